// File: rtl/emit_header.sv
// Prepends one header struct to the front of an AXIS packet, shifting every
// payload beat up by HB bytes and emitting a flush beat when the tail overflows.
module emit_header #(
   parameter int BUF_DATA_WIDTH       = 512,
   parameter int BUF_KEEP_WIDTH       = 64,
   parameter int EMITTED_STRUCT_WIDTH = 112
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [BUF_DATA_WIDTH-1:0]       s_inbuf_axis_tdata,
   input  logic [BUF_KEEP_WIDTH-1:0]       s_inbuf_axis_tkeep,
   input  logic                            s_inbuf_axis_tlast,
   input  logic                            s_inbuf_axis_tvalid,
   output logic                            s_inbuf_axis_tready,
   input  logic [EMITTED_STRUCT_WIDTH-1:0] s_struct_axis_tdata,
   input  logic                            s_struct_axis_tvalid,
   output logic                            s_struct_axis_tready,
   output logic [BUF_DATA_WIDTH-1:0]       m_outbuf_axis_tdata,
   output logic [BUF_KEEP_WIDTH-1:0]       m_outbuf_axis_tkeep,
   output logic                            m_outbuf_axis_tlast,
   output logic                            m_outbuf_axis_tvalid,
   input  logic                            m_outbuf_axis_tready
);

   localparam int W     = BUF_DATA_WIDTH;
   localparam int K     = BUF_KEEP_WIDTH;
   localparam int HB    = EMITTED_STRUCT_WIDTH / 8;
   localparam int HBITS = HB * 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [W-1:0]     m_tdata_r, m_tdata_s;
   logic [K-1:0]     m_tkeep_r, m_tkeep_s;
   logic             m_tlast_r, m_tlast_s;
   logic             m_tvalid_r, m_tvalid_s;
   logic [HBITS-1:0] carry_data_r, carry_data_s;
   logic [HB-1:0]    carry_keep_r, carry_keep_s;

   logic             ld_s;
   logic             ovf_s;
   logic             take_s;
   logic [W-1:0]     din_s;
   logic [HBITS-1:0] head_data_s;
   logic [HB-1:0]    head_keep_s;

   // Zero every data byte whose keep bit is clear so padding never leaks out.
   function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] d, input logic [K-1:0] k);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < K; i++) begin
         r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
      end
      return r;
   endfunction

   assign ld_s    = !m_tvalid_r || m_outbuf_axis_tready;
   assign ovf_s   = |s_inbuf_axis_tkeep[K-1 -: HB];
   assign din_s   = mask_bytes(s_inbuf_axis_tdata, s_inbuf_axis_tkeep);
   assign take_s  = s_inbuf_axis_tvalid && s_inbuf_axis_tready;

   // The header leads the first beat; later beats are led by the previous tail.
   assign head_data_s = (state_r == ST_IDLE) ? s_struct_axis_tdata : carry_data_r;
   assign head_keep_s = (state_r == ST_IDLE) ? {HB{1'b1}} : carry_keep_r;

   assign s_inbuf_axis_tready  = rst && ld_s &&
                                 ((state_r == ST_IDLE) ? s_struct_axis_tvalid : (state_r == ST_STREAM));
   assign s_struct_axis_tready = rst && ld_s && (state_r == ST_IDLE) && s_inbuf_axis_tvalid;

   assign m_outbuf_axis_tdata  = m_tdata_r;
   assign m_outbuf_axis_tkeep  = m_tkeep_r;
   assign m_outbuf_axis_tlast  = m_tlast_r;
   assign m_outbuf_axis_tvalid = m_tvalid_r;

   // Next-state and output-register load logic.
   always_comb begin
      state_s      = state_r;
      m_tdata_s    = m_tdata_r;
      m_tkeep_s    = m_tkeep_r;
      m_tlast_s    = m_tlast_r;
      m_tvalid_s   = m_tvalid_r;
      carry_data_s = carry_data_r;
      carry_keep_s = carry_keep_r;
      case (state_r)
         ST_IDLE, ST_STREAM: begin
            if (take_s) begin
               m_tdata_s    = {din_s[W-1-HBITS:0], head_data_s};
               m_tkeep_s    = {s_inbuf_axis_tkeep[K-1-HB:0], head_keep_s};
               carry_data_s = din_s[W-1 -: HBITS];
               carry_keep_s = s_inbuf_axis_tkeep[K-1 -: HB];
               m_tvalid_s   = 1'b1;
               m_tlast_s    = s_inbuf_axis_tlast && !ovf_s;
               if (s_inbuf_axis_tlast) begin
                  state_s = ovf_s ? ST_FLUSH : ST_IDLE;
               end else begin
                  state_s = ST_STREAM;
               end
            end else if (ld_s) begin
               m_tvalid_s = 1'b0;
            end else begin
               m_tvalid_s = m_tvalid_r;
            end
         end
         ST_FLUSH: begin
            if (ld_s) begin
               m_tdata_s  = {{(W-HBITS){1'b0}}, carry_data_r};
               m_tkeep_s  = {{(K-HB){1'b0}}, carry_keep_r};
               m_tlast_s  = 1'b1;
               m_tvalid_s = 1'b1;
               state_s    = ST_IDLE;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            m_tvalid_s = 1'b0;
         end
      endcase
   end

   // State, carry and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         m_tdata_r    <= '0;
         m_tkeep_r    <= '0;
         m_tlast_r    <= 1'b0;
         m_tvalid_r   <= 1'b0;
         carry_data_r <= '0;
         carry_keep_r <= '0;
      end else begin
         state_r      <= state_s;
         m_tdata_r    <= m_tdata_s;
         m_tkeep_r    <= m_tkeep_s;
         m_tlast_r    <= m_tlast_s;
         m_tvalid_r   <= m_tvalid_s;
         carry_data_r <= carry_data_s;
         carry_keep_r <= carry_keep_s;
      end
   end

endmodule
